// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the single memory port. While idle, CPU cycles pass
// straight through to memory. A CPU write to the DMA register starts a copy of
// DMA_LEN bytes from {value,8'h00} to OAM, and the CPU is stalled until it ends.
// Optional feature: define OAM_DMA_DONE_IRQ_EN to add the dma_done pulse output.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter int          DMA_LEN      = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic        mem_wait_n,
  output logic        dma_active
`ifdef OAM_DMA_DONE_IRQ_EN
  ,
  output logic        dma_done
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // Final index is compared before incrementing, so an 8-bit idx covers 256.
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state;
  logic [7:0]  dma_reg;
  logic [7:0]  idx;
  logic        wr_prev;    // cpu_wr_n last cycle; write accepted only on its falling edge
  logic        rd_reg_q;   // last cycle was an accepted read of the DMA register

  logic        reg_hit;
  logic        cpu_acc;
  logic        wr_accept;
  logic [7:0]  src_hi;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  assign reg_hit   = (cpu_addr == DMA_REG_ADDR);
  assign cpu_acc   = !cpu_rd_n || !cpu_wr_n;
  assign wr_accept = (state == IDLE) && reg_hit && !cpu_wr_n && wr_prev;

  // Pages above 0xDF fold down into the echo-RAM source; dma_reg keeps the raw value.
  assign src_hi    = (dma_reg > 8'hDF) ? (dma_reg - 8'h20) : dma_reg;
  assign src_addr  = {src_hi, idx};
  assign dst_addr  = DST_BASE + {8'h00, idx};

  assign dma_active = (state != IDLE);

  // Transfer FSM, DMA register and CPU strobe history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dma_reg  <= 8'h00;
      idx      <= 8'h00;
      wr_prev  <= 1'b1;
      rd_reg_q <= 1'b0;
    end else begin
      wr_prev  <= cpu_wr_n;
      rd_reg_q <= (state == IDLE) && reg_hit && !cpu_rd_n;
      case (state)
        IDLE: begin
          if (wr_accept) begin
            dma_reg <= cpu_data_in;
            idx     <= 8'h00;
            state   <= RD;
          end
        end
        RD: state <= WR;
        WR: begin
          if (idx == LAST_IDX) begin
            idx   <= 8'h00;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'h01;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port mux: CPU pass-through when idle, DMA source/destination otherwise.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_data_in;
    mem_rd_n   = 1'b1;
    mem_wr_n   = 1'b1;
    cpu_wait_n = 1'b1;
    case (state)
      IDLE: begin
        // DMA register accesses are served locally and never reach memory.
        if (!reg_hit) begin
          mem_rd_n   = cpu_rd_n;
          mem_wr_n   = cpu_wr_n;
          cpu_wait_n = mem_wait_n;
        end
      end
      RD: begin
        mem_addr   = src_addr;
        mem_rd_n   = 1'b0;
        cpu_wait_n = !cpu_acc;
      end
      WR: begin
        mem_addr   = dst_addr;
        mem_wdata  = mem_rdata;
        mem_wr_n   = 1'b0;
        cpu_wait_n = !cpu_acc;
      end
      default: begin
        cpu_wait_n = !cpu_acc;
      end
    endcase
  end

  // Register reads return one cycle late, lining up with memory read latency.
  assign cpu_data_out = rd_reg_q ? dma_reg : mem_rdata;

`ifdef OAM_DMA_DONE_IRQ_EN
  // One-cycle pulse on the first idle cycle after the final OAM write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dma_done <= 1'b0;
    else        dma_done <= (state == WR) && (idx == LAST_IDX);
  end
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: a reference memory image predicts every
// memory write and CPU read result; a negedge monitor pops and compares them.
module tb_oam_dma_arbiter;
  localparam int          LEN = 160;
  localparam logic [15:0] REG = 16'hFF46;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic [7:0]  cpu_data_out;
  logic        cpu_wait_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic        mem_wait_n = 1'b1;
  logic        dma_active;
`ifdef OAM_DMA_DONE_IRQ_EN
  logic        dma_done;
`endif

  oam_dma_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_data_out(cpu_data_out), .cpu_wait_n(cpu_wait_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_wait_n(mem_wait_n),
    .dma_active(dma_active)
`ifdef OAM_DMA_DONE_IRQ_EN
    , .dma_done(dma_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  ref_dma = 8'h00;
  logic [7:0]  cur_src_hi = 8'h00;
  wr_t         exp_wr[$];
  logic [7:0]  exp_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Memory model: random image, VRAM pattern, 1-cycle registered read data.
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < LEN; i++) mem[16'h8000 + 16'(i)] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (!mem_wr_n) mem[mem_addr] = mem_wdata;
      if (!mem_rd_n) mem_rdata = mem[mem_addr];
    end
  end

  // Monitor: checks every memory write and every completed CPU read.
  initial begin
    bit rd_pend;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (exp_rd.size() == 0) fail_note("rd_unexpected", 32'(cpu_data_out));
        else chk("rd_data", 32'(cpu_data_out), 32'(exp_rd.pop_front()));
      end
      rd_pend = rst_n && !cpu_rd_n && cpu_wait_n;
      if (rst_n) begin
        if (!mem_rd_n || !mem_wr_n) chk("one_strobe", 32'(mem_rd_n ^ mem_wr_n), 1);
        if (!mem_wr_n) begin
          if (exp_wr.size() == 0) fail_note("wr_unexpected", 32'(mem_addr));
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", 32'(mem_wdata), 32'(e.data));
          end
        end
        if (dma_active && !mem_rd_n) chk("src_page", 32'(mem_addr[15:8]), 32'(cur_src_hi));
`ifdef OAM_DMA_DONE_IRQ_EN
        if (dma_done) done_cnt++;
`endif
      end
    end
  end

  task automatic cpu_read(input logic [15:0] a, input bit wait_rand);
    exp_rd.push_back((a == REG) ? ref_dma : ref_mem[a]);
    @(posedge clk); #1;
    cpu_addr = a;
    cpu_rd_n = 1'b0;
    for (int t = 0; t < 20; t++) begin
      mem_wait_n = (wait_rand && t < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (a == REG) chk("reg_rd_fwd", 32'(mem_rd_n), 1);
      else begin
        chk("rd_fwd_strobe", 32'(mem_rd_n), 0);
        chk("rd_fwd_addr", 32'(mem_addr), 32'(a));
        chk("wait_track", 32'(cpu_wait_n), 32'(mem_wait_n));
      end
      if (cpu_wait_n) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_rd_n   = 1'b1;
    mem_wait_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
    ref_mem[a] = d;
    @(posedge clk); #1;
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_wr_n    = 1'b0;
    @(negedge clk);
    chk("wr_wait", 32'(cpu_wait_n), 1);
    @(posedge clk); #1;
    cpu_wr_n = 1'b1;
  endtask

  // One DMA: hold = cycle wr_n is released, n_exp = bytes expected in OAM,
  // abort_at = cycle to assert reset (0 = none), stall_at = cycle a read of 0xFF80 starts (0 = none).
  task automatic run_dma(input logic [7:0] v, input int hold, input int n_exp,
                         input int abort_at, input int stall_at);
    logic [7:0] hi;
    int act_cnt, d0;
    bit rel_rd, fin;
    hi = (v > 8'hDF) ? v - 8'h20 : v;
    cur_src_hi = hi;
    for (int i = 0; i < n_exp; i++) begin
      wr_t e;
      e.addr = 16'hFE00 + 16'(i);
      e.data = ref_mem[{hi, 8'(i)}];
      exp_wr.push_back(e);
      ref_mem[e.addr] = e.data;
    end
    ref_dma = v;
    d0 = done_cnt; act_cnt = 0; rel_rd = 0; fin = 0;
    @(posedge clk); #1;
    cpu_addr    = REG;
    cpu_data_in = v;
    cpu_wr_n    = 1'b0;
    @(negedge clk);
    chk("dma_not_yet", 32'(dma_active), 0);
    chk("reg_wr_fwd", 32'(mem_wr_n), 1);
    for (int c = 1; c <= 1200; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        rst_n = 1'b0; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
        #1;
        chk("abort_active", 32'(dma_active), 0);
        chk("abort_rd_n", 32'(mem_rd_n), 1);
        chk("abort_wr_n", 32'(mem_wr_n), 1);
        chk("abort_wr_left", 32'(exp_wr.size()), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ref_dma = 8'h00;
        fin = 1;
        break;
      end
      if (c == hold) cpu_wr_n = 1'b1;
      if (rel_rd) cpu_rd_n = 1'b1;
      if (c == stall_at) begin
        cpu_addr = 16'hFF80;
        cpu_rd_n = 1'b0;
        exp_rd.push_back(ref_mem[16'hFF80]);
      end
      @(negedge clk);
      if (dma_active) begin
        act_cnt++;
        if (!cpu_rd_n || !cpu_wr_n) chk("stall_wait", 32'(cpu_wait_n), 0);
      end else if (!cpu_rd_n && !rel_rd) begin
        chk("stall_fwd_rd", 32'(mem_rd_n), 0);
        chk("stall_fwd_addr", 32'(mem_addr), 32'h0000FF80);
        chk("stall_fwd_wait", 32'(cpu_wait_n), 1);
        rel_rd = 1;
      end
`ifdef OAM_DMA_DONE_IRQ_EN
      if (c == 2 * LEN)     chk("done_early", 32'(dma_done), 0);
      if (c == 2 * LEN + 1) chk("done_pulse", 32'(dma_done), 1);
`endif
      if (!dma_active && c > 2 * LEN && c >= hold && cpu_rd_n) begin
        fin = 1;
        break;
      end
    end
    if (!fin) fail_note("dma_timeout", 32'(act_cnt));
    if (abort_at == 0) chk("active_cycles", 32'(act_cnt), 2 * LEN);
    else               chk("abort_active_cycles", 32'(act_cnt), 32'(abort_at - 1));
    @(negedge clk);
`ifdef OAM_DMA_DONE_IRQ_EN
    chk("done_count", 32'(done_cnt - d0), (abort_at == 0) ? 1 : 0);
`endif
  endtask

  task automatic random_traffic(input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom);
        if (a == REG) a = 16'hFF47;
        cpu_read(a, 1'b1);
      end else begin
        cpu_write(16'($urandom_range(16'hA000, 16'hFEFF)), 8'($urandom));
      end
    end
  endtask

  initial begin
    #1;
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
    @(negedge clk);
    chk("rst_active", 32'(dma_active), 0);
    chk("rst_rd_n", 32'(mem_rd_n), 1);
    chk("rst_wr_n", 32'(mem_wr_n), 1);
    chk("rst_wait_n", 32'(cpu_wait_n), 1);
    chk("rst_data_out", 32'(cpu_data_out), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cpu_read(16'hC123, 1'b1);
    random_traffic(20);

    run_dma(8'h80, 1, LEN, 0, 0);
    for (int i = 0; i < LEN; i++)
      chk("oam_pattern", 32'(mem[16'hFE00 + 16'(i)]), 32'(8'(i) ^ 8'h5A));

    run_dma(8'hC0, 1, LEN, 0, 0);
    cpu_read(REG, 1'b0);

    run_dma(8'($urandom), 1, LEN, 0, 10);
    run_dma(8'hFE, 400, LEN, 0, 0);
    cpu_read(REG, 1'b0);

    for (int k = 0; k < 2; k++) begin
      random_traffic(8);
      run_dma(8'($urandom), 1 + int'($urandom_range(0, 3)), LEN, 0, 0);
    end

    run_dma(8'($urandom), 1, 50, 101, 0);
    cpu_read(REG, 1'b0);
    run_dma(8'h81, 1, LEN, 0, 0);
    random_traffic(6);

    repeat (3) @(negedge clk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sits between the CPU bus and the memory interface; owns the single memory port.
- Idle: forwards CPU cycles transparently to the memory interface.
- A CPU write to the DMA register (0xFF46) starts an OAM DMA that copies DMA_LEN bytes from (value<<8) to 0xFE00. The CPU is stalled via cpu_wait_n for the duration.
- Also implements the DMA register, which is readable.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- DST_BASE, 16'hFE00, destination base (OAM).
- DMA_LEN, 160, bytes per transfer (1..256).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU address
- cpu_data_in  in  8  CPU write data
- cpu_rd_n  in  1  CPU read strobe, active low
- cpu_wr_n  in  1  CPU write strobe, active low
- cpu_data_out  out  8  read data to CPU, valid 1 cycle after the read cycle
- cpu_wait_n  out  1  low = CPU access not accepted this cycle
- mem_addr  out  16  address to the memory interface
- mem_wdata  out  8  write data to the memory interface
- mem_rdata  in  8  registered read data from the memory interface (1-cycle latency)
- mem_rd_n  out  1  read strobe to memory, active low
- mem_wr_n  out  1  write strobe to memory, active low
- mem_wait_n  in  1  wait from the memory interface, forwarded to the CPU when idle
- dma_active  out  1  high while a transfer is in progress

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset state: state=IDLE, dma_reg=8'h00, idx=0, dma_active=0, cpu_data_out=8'h00, wr_prev=1.
  - mem_rd_n=1, mem_wr_n=1, cpu_wait_n=1.
  - Reset mid-transfer aborts immediately; OAM keeps whatever bytes were already written.
- IDLE, CPU address != DMA_REG_ADDR:
  - Combinational pass-through: mem_addr=cpu_addr, mem_wdata=cpu_data_in, mem_rd_n=cpu_rd_n, mem_wr_n=cpu_wr_n, cpu_wait_n=mem_wait_n.
  - cpu_data_out = mem_rdata, held in a register-free mux selected by a 1-cycle-delayed "last read was DMA reg" flag.
- IDLE, CPU read of DMA_REG_ADDR:
  - Not forwarded (mem_rd_n=1).
  - cpu_data_out = dma_reg on the following cycle, matching memory read latency.
- IDLE, CPU write of DMA_REG_ADDR:
  - Not forwarded (mem_wr_n=1).
  - Accepted only on the first cycle of a write (cpu_wr_n low and wr_prev high). Holding wr_n low does not retrigger.
  - On acceptance: dma_reg <= cpu_data_in, idx <= 0, state <= RD.
- Source address: src = {dma_reg,8'h00} + idx.
  - If dma_reg > 8'hDF, the high byte used is dma_reg - 8'h20 (echo-RAM fold).
  - dma_reg itself keeps the written value.
- RD state: mem_addr=src, mem_rd_n=0, mem_wr_n=1; next state WR.
- WR state: mem_addr=DST_BASE+idx, mem_wdata=mem_rdata, mem_wr_n=0, mem_rd_n=1.
  - If idx==DMA_LEN-1: next state IDLE, idx<=0.
  - Otherwise: idx<=idx+1, next state RD.
- Timing:
  - 2 cycles per byte; a transfer occupies exactly 2*DMA_LEN cycles (320 at default), starting the cycle after the accepting write.
  - idx is 8 bits; the final compare is done before increment, so no wrap.
- dma_active = (state != IDLE).
- While dma_active=1:
  - Any CPU access (cpu_rd_n=0 or cpu_wr_n=0), including to DMA_REG_ADDR, sees cpu_wait_n=0 and is not forwarded.
  - The CPU must hold the access; it completes normally on the first IDLE cycle.
  - cpu_wait_n=1 when the CPU is not accessing.
- A stalled DMA_REG_ADDR write is accepted after completion only if wr_prev=1, i.e. the CPU has released and reasserted wr_n.
- mem_wait_n is ignored during DMA; source reads from ROM still complete in 1 cycle.

Optional Feature:
- Macro OAM_DMA_DONE_IRQ_EN.
  - Defined: adds output dma_done (1 bit, reset 0), a registered one-cycle pulse on the cycle after the final WR cycle, i.e. the first IDLE cycle.
  - Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Pass-through: CPU read 0xC123 idle -> mem_addr=0xC123, mem_rd_n=0 same cycle; next cycle cpu_data_out=mem_rdata; cpu_wait_n tracks mem_wait_n.
- Basic DMA: write 0x80 to 0xFF46 with VRAM 0x8000..0x809F = i^0x5A -> dma_active high for exactly 320 cycles; OAM 0xFE00+i = i^0x5A; memory writes seen only to 0xFE00..0xFE9F.
- Register readback: write 0xC0 to 0xFF46, wait done, read 0xFF46 -> cpu_data_out=0xC0 one cycle later; mem_rd_n stays 1.
- Stall: CPU read 0xFF80 issued 10 cycles into DMA -> cpu_wait_n=0 until dma_active falls, then the read is forwarded; no bus conflict during DMA.
- Fold and hold: write 0xFE to 0xFF46 with wr_n held low 400 cycles -> source 0xDE00..0xDE9F, exactly one transfer.
- Reset mid-transfer at idx=50 -> all strobes high and dma_active=0 immediately; with OAM_DMA_DONE_IRQ_EN, no dma_done pulse; a normal run gives exactly one pulse.
